// File: rtl/seq_pkg.sv
// Shared definitions for the multi-cycle RV32I control sequencer:
// opcode constants, FSM state encoding, instruction classes and the
// select/fault codes driven onto the datapath.
package seq_pkg;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Encodings are visible on state_dbg, so values are pinned explicitly.
  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    CLS_NONE,
    CLS_ALU_R,
    CLS_ALU_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC
  } op_class_t;

  // Register-file write-back source
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_t;

  // Next-PC source
  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_JALR  = 2'd2
  } pc_sel_t;

  // Sticky fault cause
  typedef enum logic [1:0] {
    FAULT_NONE    = 2'd0,
    FAULT_ILLEGAL = 2'd1,
    FAULT_TIMEOUT = 2'd2
  } fault_t;

endpackage

// File: rtl/seq_op_classifier.sv
// Purely combinational opcode decoder: maps instr[6:0] onto an
// instruction class and flags anything outside the supported RV32I set.
module seq_op_classifier
  import seq_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class,
  output logic       illegal
);

  // Opcode lookup; unknown opcodes report CLS_NONE and raise illegal.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    op_class = CLS_NONE;
    illegal  = 1'b0;
    case (opcode)
      OP_R:      op_class = CLS_ALU_R;
      OP_I:      op_class = CLS_ALU_I;
      OP_LOAD:   op_class = CLS_LOAD;
      OP_STORE:  op_class = CLS_STORE;
      OP_BRANCH: op_class = CLS_BRANCH;
      OP_JAL:    op_class = CLS_JAL;
      OP_JALR:   op_class = CLS_JALR;
      OP_LUI:    op_class = CLS_LUI;
      OP_AUIPC:  op_class = CLS_AUIPC;
      default:   illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for a shared RV32I datapath (one memory port,
// one ALU, one register file). Walks FETCH/DECODE/EXECUTE/MEM/WB per
// instruction, handshakes with the unified memory port and parks in TRAP
// on an illegal opcode or a memory timeout.
//
// Optional build macro: SEQ_SINGLE_STEP_EN adds a step_req input; FETCH
// then waits for a step pulse before requesting each instruction.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic       step_req,
`endif
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       instr_retired,
  output logic [1:0] fault,
  output logic [2:0] state_dbg
);

  localparam int              CNT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state;
  state_t           state_next;
  op_class_t        op_class_q;
  op_class_t        dec_class;
  logic             dec_illegal;
  fault_t           fault_q;
  fault_t           fault_set;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_limit;
  logic             fetch_go;

  seq_op_classifier u_classifier (
    .opcode   (opcode),
    .op_class (dec_class),
    .illegal  (dec_illegal)
  );

`ifdef SEQ_SINGLE_STEP_EN
  logic step_pending;

  // Remember a step pulse until the instruction it releases is fetched;
  // a fresh pulse in the fetch cycle itself queues the next instruction.
  always_ff @(posedge clk) begin
    if (reset)          step_pending <= 1'b0;
    else if (step_req)  step_pending <= 1'b1;
    else if (ir_we)     step_pending <= 1'b0;
  end

  assign fetch_go = step_pending;
`else
  assign fetch_go = 1'b1;
`endif

  assign wait_limit = (wait_cnt == CNT_LIMIT);
  assign fault      = fault_q;
  assign state_dbg  = state;

  // State, latched class and sticky fault registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    if (reset) begin
      state      <= ST_FETCH;
      op_class_q <= CLS_NONE;
      fault_q    <= FAULT_NONE;
    end else begin
      state <= state_next;
      if (state == ST_DECODE) op_class_q <= dec_class;
      if (fault_set != FAULT_NONE) fault_q <= fault_set;
    end
  end

  // Memory wait counter: counts stalled request cycles, restarts on a
  // completed transfer or whenever the FSM moves to another state.
  always_ff @(posedge clk) begin
    if (reset)                                          wait_cnt <= '0;
    else if (state_next != state || (mem_req && mem_ready)) wait_cnt <= '0;
    else if (mem_req)                                   wait_cnt <= wait_cnt + 1'b1;
  end

  // Next-state and datapath control, decoded from the current state,
  // the latched class and the live handshake/comparator inputs.
  always_comb begin
    state_next    = state;
    fault_set     = FAULT_NONE;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    addr_sel      = 1'b0;
    ir_we         = 1'b0;
    rf_we         = 1'b0;
    wb_sel        = WB_ALU;
    pc_we         = 1'b0;
    pc_sel        = PC_PLUS4;
    instr_retired = 1'b0;

    case (state)
      ST_FETCH: begin
        mem_req = fetch_go;
        if (fetch_go && mem_ready) begin
          ir_we      = 1'b1;
          state_next = ST_DECODE;
        end else if (fetch_go && wait_limit) begin
          fault_set  = FAULT_TIMEOUT;
          state_next = ST_TRAP;
        end
      end

      ST_DECODE: begin
        if (dec_illegal) begin
          fault_set  = FAULT_ILLEGAL;
          state_next = ST_TRAP;
        end else begin
          state_next = ST_EXECUTE;
        end
      end

      ST_EXECUTE: begin
        case (op_class_q)
          CLS_LOAD, CLS_STORE: state_next = ST_MEM;
          CLS_BRANCH: begin
            pc_we         = 1'b1;
            pc_sel        = branch_taken ? PC_IMM : PC_PLUS4;
            instr_retired = 1'b1;
            state_next    = ST_FETCH;
          end
          default: state_next = ST_WB;
        endcase
      end

      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (op_class_q == CLS_STORE);
        if (mem_ready) begin
          if (op_class_q == CLS_STORE) begin
            pc_we         = 1'b1;
            instr_retired = 1'b1;
            state_next    = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end else if (wait_limit) begin
          fault_set  = FAULT_TIMEOUT;
          state_next = ST_TRAP;
        end
      end

      ST_WB: begin
        rf_we         = 1'b1;
        pc_we         = 1'b1;
        instr_retired = 1'b1;
        state_next    = ST_FETCH;
        case (op_class_q)
          CLS_LOAD:           wb_sel = WB_MEM;
          CLS_JAL, CLS_JALR:  wb_sel = WB_PC4;
          CLS_LUI:            wb_sel = WB_IMM;
          default:            wb_sel = WB_ALU;
        endcase
        case (op_class_q)
          CLS_JAL:  pc_sel = PC_IMM;
          CLS_JALR: pc_sel = PC_JALR;
          default:  pc_sel = PC_PLUS4;
        endcase
      end

      ST_TRAP: state_next = ST_TRAP;

      default: state_next = ST_FETCH;
    endcase

    // Reset aborts whatever is in flight: no strobe may reach the datapath.
    if (reset) begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      addr_sel      = 1'b0;
      ir_we         = 1'b0;
      rf_we         = 1'b0;
      wb_sel        = WB_ALU;
      pc_we         = 1'b0;
      pc_sel        = PC_PLUS4;
      instr_retired = 1'b0;
      fault_set     = FAULT_NONE;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer (MEM_TIMEOUT=4). Each scenario
// steps cycle by cycle against a table of hand-derived output vectors:
// {state_dbg, mem_req, mem_we, addr_sel, ir_we, rf_we, wb_sel, pc_we,
//  pc_sel, instr_retired, fault}.
module tb_multicycle_sequencer;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       addr_sel;
  logic       ir_we;
  logic       rf_we;
  logic [1:0] wb_sel;
  logic       pc_we;
  logic [1:0] pc_sel;
  logic       instr_retired;
  logic [1:0] fault;
  logic [2:0] state_dbg;
  logic [15:0] obs;

  int vectors    = 0;
  int miscompares = 0;

  multicycle_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .branch_taken  (branch_taken),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .addr_sel      (addr_sel),
    .ir_we         (ir_we),
    .rf_we         (rf_we),
    .wb_sel        (wb_sel),
    .pc_we         (pc_we),
    .pc_sel        (pc_sel),
    .instr_retired (instr_retired),
    .fault         (fault),
    .state_dbg     (state_dbg)
  );

  assign obs = {state_dbg, mem_req, mem_we, addr_sel, ir_we, rf_we,
                wb_sel, pc_we, pc_sel, instr_retired, fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Builds one expected output vector in the same field order as obs.
  function automatic logic [15:0] v(input logic [2:0] st, input logic mreq,
      input logic mwe, input logic asel, input logic irwe, input logic rfwe,
      input logic [1:0] wbs, input logic pcwe, input logic [1:0] pcs,
      input logic ret, input logic [1:0] flt);
    return {st, mreq, mwe, asel, irwe, rfwe, wbs, pcwe, pcs, ret, flt};
  endfunction

  // Hold reset across one edge, check the quiet outputs, release.
  task automatic test_reset();
    logic [15:0] exp;
    reset     = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    exp = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL reset: got %h expected %h", obs, exp);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ADDI with zero-wait memory: F, D, E, WB, F.
  task automatic test_alu();
    logic [15:0] exp [5];
    logic        rdy [5];
    opcode       = 7'b0010011;
    branch_taken = 1'b0;
    exp = '{v(0,1,0,0,1,0,0,0,0,0,0), v(1,0,0,0,0,0,0,0,0,0,0),
            v(2,0,0,0,0,0,0,0,0,0,0), v(4,0,0,0,0,1,0,1,0,1,0),
            v(0,1,0,0,0,0,0,0,0,0,0)};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      vectors++;
      if (obs !== exp[i]) begin
        miscompares++;
        $display("FAIL alu[%0d]: got %h expected %h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // LOAD with three wait cycles in MEM; ready arrives in the limit cycle.
  task automatic test_load_wait();
    logic [15:0] exp [9];
    logic        rdy [9];
    opcode = 7'b0000011;
    exp = '{v(0,1,0,0,1,0,0,0,0,0,0), v(1,0,0,0,0,0,0,0,0,0,0),
            v(2,0,0,0,0,0,0,0,0,0,0), v(3,1,0,1,0,0,0,0,0,0,0),
            v(3,1,0,1,0,0,0,0,0,0,0), v(3,1,0,1,0,0,0,0,0,0,0),
            v(3,1,0,1,0,0,0,0,0,0,0), v(4,0,0,0,0,1,1,1,0,1,0),
            v(0,1,0,0,0,0,0,0,0,0,0)};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      vectors++;
      if (obs !== exp[i]) begin
        miscompares++;
        $display("FAIL load_wait[%0d]: got %h expected %h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // STORE: write strobe in MEM, retires there, never writes the regfile.
  task automatic test_store();
    logic [15:0] exp [5];
    logic        rdy [5];
    opcode = 7'b0100011;
    exp = '{v(0,1,0,0,1,0,0,0,0,0,0), v(1,0,0,0,0,0,0,0,0,0,0),
            v(2,0,0,0,0,0,0,0,0,0,0), v(3,1,1,1,0,0,0,1,0,1,0),
            v(0,1,0,0,0,0,0,0,0,0,0)};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      vectors++;
      if (obs !== exp[i]) begin
        miscompares++;
        $display("FAIL store[%0d]: got %h expected %h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // BEQ taken then not taken: retires in EXECUTE, back in FETCH at cycle 4.
  task automatic test_branch();
    logic [15:0] exp [8];
    logic        rdy [8];
    opcode = 7'b1100011;
    exp = '{v(0,1,0,0,1,0,0,0,0,0,0), v(1,0,0,0,0,0,0,0,0,0,0),
            v(2,0,0,0,0,0,0,1,1,1,0), v(0,1,0,0,0,0,0,0,0,0,0),
            v(0,1,0,0,1,0,0,0,0,0,0), v(1,0,0,0,0,0,0,0,0,0,0),
            v(2,0,0,0,0,0,0,1,0,1,0), v(0,1,0,0,0,0,0,0,0,0,0)};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      mem_ready    = rdy[i];
      branch_taken = (i < 4);
      @(negedge clk);
      vectors++;
      if (obs !== exp[i]) begin
        miscompares++;
        $display("FAIL branch[%0d]: got %h expected %h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
    branch_taken = 1'b0;
  endtask

  // Illegal opcode parks in TRAP with fault=1 until reset clears it.
  task automatic test_illegal();
    logic [15:0] exp;
    opcode = 7'b1111111;
    for (int i = 0; i < 22; i++) begin
      mem_ready = (i < 2) ? 1'b1 : i[0];
      if (i == 0)      exp = v(0,1,0,0,1,0,0,0,0,0,0);
      else if (i == 1) exp = v(1,0,0,0,0,0,0,0,0,0,0);
      else             exp = v(7,0,0,0,0,0,0,0,0,0,1);
      @(negedge clk);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL illegal[%0d]: got %h expected %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
    test_reset();
    mem_ready = 1'b0;
    exp = v(0,1,0,0,0,0,0,0,0,0,0);
    @(negedge clk);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL illegal_recover: got %h expected %h", obs, exp);
    end
    @(posedge clk); #1;
  endtask

  // Fetch stalls: four request cycles, then TRAP with fault=2, no ir_we.
  task automatic test_timeout();
    logic [15:0] exp;
    test_reset();
    opcode    = 7'b0010011;
    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp = (i < 4) ? v(0,1,0,0,0,0,0,0,0,0,0) : v(7,0,0,0,0,0,0,0,0,0,2);
      @(negedge clk);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL timeout[%0d]: got %h expected %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  // Reset during MEM: strobes drop immediately, FETCH on the next cycle.
  task automatic test_reset_mid_mem();
    logic [15:0] exp [4];
    logic        rdy [4];
    test_reset();
    opcode = 7'b0000011;
    exp = '{v(0,1,0,0,1,0,0,0,0,0,0), v(1,0,0,0,0,0,0,0,0,0,0),
            v(2,0,0,0,0,0,0,0,0,0,0), v(3,1,0,1,0,0,0,0,0,0,0)};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      vectors++;
      if (obs !== exp[i]) begin
        miscompares++;
        $display("FAIL mid_mem[%0d]: got %h expected %h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
    reset     = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs !== v(3,0,0,0,0,0,0,0,0,0,0)) begin
      miscompares++;
      $display("FAIL mid_mem_abort: got %h expected %h", obs,
               v(3,0,0,0,0,0,0,0,0,0,0));
    end
    @(posedge clk); #1;
    reset     = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs !== v(0,1,0,0,0,0,0,0,0,0,0)) begin
      miscompares++;
      $display("FAIL mid_mem_refetch: got %h expected %h", obs,
               v(0,1,0,0,0,0,0,0,0,0,0));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset        = 1'b1;
    opcode       = 7'b0010011;
    branch_taken = 1'b0;
    mem_ready    = 1'b0;
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
